// File: rtl/mac_pkg.sv
// Shared defaults, FSM encoding and saturation bounds for the MAC accumulation lane.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mac_pkg;

    localparam int MAC_OUT_WIDTH_DEF = 18;
    localparam int ACC_WIDTH_DEF     = 24;
    localparam int LEN_WIDTH_DEF     = 8;

    // ACC: collecting products; HOLD: presenting a finished group sum
    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Largest value representable in a w-bit two's complement word
    function automatic logic signed [63:0] sat_hi(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a w-bit two's complement word
    function automatic logic signed [63:0] sat_lo(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/sat_add.sv
// Signed W-bit add evaluated at W+1 bits, clamped back to W bits with a clip flag.
// Latency: combinational.
// Backpressure: none.
module sat_add
    import mac_pkg::*;
#(
    parameter int W = ACC_WIDTH_DEF
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                clip
);

    localparam logic signed [W-1:0] HI = W'(sat_hi(W));
    localparam logic signed [W-1:0] LO = W'(sat_lo(W));

    logic [W:0] wide;

    // One guard bit catches overflow; a mismatch between the top two bits means the W-bit result is out of range
    always_comb begin
        wide = {a[W-1], a} + {b[W-1], b};
        clip = wide[W] ^ wide[W-1];
        if (!clip) begin
            sum = wide[W-1:0];
        end else if (wide[W]) begin
            sum = LO;
        end else begin
            sum = HI;
        end
    end

endmodule

// File: rtl/mac_accumulator.sv
// Sums groups of signed products into a saturating accumulator; emits each group sum with a sticky overflow flag.
// Latency: closing product accepted at edge t gives out_valid_o from t+1; one product per cycle while collecting.
// Backpressure: prod_ready_o drops while a result is held; the next group starts the edge after the output handshake.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int MAC_OUT_WIDTH = MAC_OUT_WIDTH_DEF,
    parameter int ACC_WIDTH     = ACC_WIDTH_DEF,
    parameter int LEN_WIDTH     = LEN_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 prod_valid_i,
    output logic                 prod_ready_o,
    input  logic [MAC_OUT_WIDTH-1:0] prod_i,
    input  logic                 prod_last_i,
    input  logic [LEN_WIDTH-1:0] acc_len_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [ACC_WIDTH-1:0] out_data_o,
    output logic                 out_ovf_o
);

    state_t state, state_nxt;

    logic signed [ACC_WIDTH-1:0] acc;
    logic [LEN_WIDTH-1:0]        cnt;
    logic [LEN_WIDTH-1:0]        len_q;
    logic                        ovf_acc;

    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] sum_sat;
    logic                        clip;
    logic                        accept;
    logic                        first;
    logic [LEN_WIDTH-1:0]        len_eff;
    logic                        close;

    assign prod_ext = ACC_WIDTH'($signed(prod_i));
    assign accept   = prod_valid_i & prod_ready_o;
    assign first    = (cnt == '0);
    // On the first product len_q is not loaded yet, so the live length input decides (len=1 closes at once)
    assign len_eff  = first ? acc_len_i : len_q;
    assign close    = accept & (prod_last_i |
                      ((len_eff != '0) && (cnt == len_eff - LEN_WIDTH'(1))));

    sat_add #(.W(ACC_WIDTH)) u_sat_add (
        .a    (acc),
        .b    (prod_ext),
        .sum  (sum_sat),
        .clip (clip)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: abort wins, otherwise close a group or release a held result
    always_comb begin
        state_nxt = state;
        if (clr_i) begin
            state_nxt = ACC;
        end else begin
            case (state)
                ACC:     if (close)       state_nxt = HOLD;
                HOLD:    if (out_ready_i) state_nxt = ACC;
                default: state_nxt = ACC;
            endcase
        end
    end

    // Handshake outputs decoded from state; ready is masked while reset is held
    always_comb begin
        prod_ready_o = (state == ACC) && !rst;
        out_valid_o  = (state == HOLD);
    end

    // Accumulator, group counter, length latch and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            cnt        <= '0;
            len_q      <= '0;
            ovf_acc    <= 1'b0;
            out_data_o <= '0;
            out_ovf_o  <= 1'b0;
        end else if (clr_i) begin
            acc     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
        end else if (accept) begin
            if (first) begin
                len_q <= acc_len_i;
            end
            if (close) begin
                out_data_o <= sum_sat;
                out_ovf_o  <= ovf_acc | clip;
                acc        <= '0;
                cnt        <= '0;
                ovf_acc    <= 1'b0;
            end else begin
                acc     <= sum_sat;
                cnt     <= cnt + LEN_WIDTH'(1);
                ovf_acc <= ovf_acc | clip;
            end
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: directed scenarios plus randomized traffic against a group-level model.
// Latency: n/a.
// Backpressure: randomized on both handshakes.
module tb_mac_accumulator;

    localparam int PW   = 18;
    localparam int AW   = 20;
    localparam int LW   = 8;
    localparam int MAXV = (1 << (AW - 1)) - 1;
    localparam int MINV = -(1 << (AW - 1));

    logic          clk = 1'b0;
    logic          rst;
    logic          clr_i;
    logic          prod_valid_i;
    logic          prod_ready_o;
    logic [PW-1:0] prod_i;
    logic          prod_last_i;
    logic [LW-1:0] acc_len_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [AW-1:0] out_data_o;
    logic          out_ovf_o;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: group-level view of the lane
    bit m_hold;
    int m_data;
    bit m_ovf;
    int m_sum;
    bit m_gov;
    int m_cnt;
    int m_len;
    bit m_was_rst;

    mac_accumulator #(
        .MAC_OUT_WIDTH (PW),
        .ACC_WIDTH     (AW),
        .LEN_WIDTH     (LW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (clr_i),
        .prod_valid_i (prod_valid_i),
        .prod_ready_o (prod_ready_o),
        .prod_i       (prod_i),
        .prod_last_i  (prod_last_i),
        .acc_len_i    (acc_len_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_ovf_o    (out_ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock of behaviour from the lane's rules: groups, saturation, hold, abort, reset
    task automatic model_step(input bit v, input int p, input bit last, input int len,
                              input bit ordy, input bit c, input bit r);
        int s;
        m_was_rst = r;
        if (r) begin
            m_hold = 0; m_data = 0; m_ovf = 0;
            m_sum = 0; m_gov = 0; m_cnt = 0; m_len = 0;
        end else if (c) begin
            m_hold = 0; m_sum = 0; m_gov = 0; m_cnt = 0;
        end else if (m_hold) begin
            if (ordy) m_hold = 0;
        end else if (v) begin
            if (m_cnt == 0) m_len = len;
            s = m_sum + p;
            if (s > MAXV) begin s = MAXV; m_gov = 1; end
            if (s < MINV) begin s = MINV; m_gov = 1; end
            m_sum = s;
            m_cnt = (m_cnt + 1) % (1 << LW);
            if (last || (m_len != 0 && m_cnt == m_len)) begin
                m_data = m_sum; m_ovf = m_gov; m_hold = 1;
                m_sum = 0; m_gov = 0; m_cnt = 0;
            end
        end
    endtask

    // Drive one cycle, check ready before the edge and the outputs after it
    task automatic cyc(input bit v, input int p, input bit last, input int len,
                       input bit ordy, input bit c, input bit r);
        prod_valid_i = v;
        prod_i       = p[PW-1:0];
        prod_last_i  = last;
        acc_len_i    = len[LW-1:0];
        out_ready_i  = ordy;
        clr_i        = c;
        rst          = r;
        #1;
        chk("prod_ready", prod_ready_o, (!m_hold && !r));
        model_step(v, p, last, len, ordy, c, r);
        @(posedge clk);
        #1;
        chk("out_valid", out_valid_o, m_hold);
        if (m_hold || m_was_rst) begin
            chk("out_data", $signed(out_data_o), m_data);
            chk("out_ovf", out_ovf_o, m_ovf);
        end
    endtask

    task automatic idle(input bit ordy);
        cyc(0, 0, 0, 0, ordy, 0, 0);
    endtask

    initial begin
        m_hold = 0; m_data = 0; m_ovf = 0; m_sum = 0; m_gov = 0;
        m_cnt = 0; m_len = 0; m_was_rst = 0;

        // Reset
        cyc(0, 0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 1, 0, 1);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_data", $signed(out_data_o), 0);
        idle(1);

        // len=4 group
        cyc(1, 100, 0, 4, 1, 0, 0);
        cyc(1, -50, 0, 4, 1, 0, 0);
        cyc(1, 255, 0, 4, 1, 0, 0);
        cyc(1, -1, 0, 4, 1, 0, 0);
        chk("t1_valid", out_valid_o, 1);
        chk("t1_sum", $signed(out_data_o), 304);
        chk("t1_ovf", out_ovf_o, 0);
        idle(1);
        chk("t1_one_cycle", out_valid_o, 0);

        // Saturation then sticky flag cleared on the next group
        for (int i = 0; i < 8; i++) cyc(1, 65536, 0, 8, 1, 0, 0);
        chk("t2_sat", $signed(out_data_o), 524287);
        chk("t2_ovf", out_ovf_o, 1);
        idle(1);
        cyc(1, -3, 0, 2, 1, 0, 0);
        cyc(1, 3, 0, 2, 1, 0, 0);
        chk("t2_zero", $signed(out_data_o), 0);
        chk("t2_ovf_clr", out_ovf_o, 0);
        idle(1);

        // Unbounded group closed by last; last before len
        cyc(1, 7, 0, 0, 1, 0, 0);
        cyc(1, 7, 0, 0, 1, 0, 0);
        cyc(1, 7, 1, 0, 1, 0, 0);
        chk("t3_unbounded", $signed(out_data_o), 21);
        idle(1);
        cyc(1, 10, 0, 5, 1, 0, 0);
        cyc(1, 20, 1, 5, 1, 0, 0);
        chk("t3_early_last", $signed(out_data_o), 30);
        idle(1);

        // Consumer stall while the producer keeps offering
        cyc(1, 5, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1000 + i, 0, 1, 0, 0, 0);
            chk("t4_stall_data", $signed(out_data_o), 5);
        end
        cyc(1, 77, 0, 1, 1, 0, 0);
        chk("t4_released", out_valid_o, 0);
        cyc(1, 8, 0, 1, 1, 0, 0);
        chk("t4_resume", $signed(out_data_o), 8);
        idle(1);

        // Abort discards the partial group and a concurrent product
        cyc(1, 9, 0, 4, 1, 0, 0);
        cyc(1, 9, 0, 4, 1, 0, 0);
        cyc(1, 100, 0, 4, 1, 1, 0);
        chk("t5_no_out", out_valid_o, 0);
        cyc(1, -65536, 0, 1, 1, 0, 0);
        chk("t5_neg", $signed(out_data_o), -65536);
        idle(1);

        // Reset in HOLD and mid-group
        cyc(1, 3, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("t6_hold_rst", out_valid_o, 0);
        idle(1);
        cyc(1, 1, 0, 4, 1, 0, 0);
        cyc(1, 2, 0, 4, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 1);
        idle(1);
        cyc(1, 4, 0, 2, 1, 0, 0);
        cyc(1, 5, 0, 2, 1, 0, 0);
        chk("t6_fresh", $signed(out_data_o), 9);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 9) < 7),
                int'($urandom_range(0, (1 << PW) - 1)) - (1 << (PW - 1)),
                ($urandom_range(0, 7) == 0),
                int'($urandom_range(0, 6)),
                ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 199) == 0));
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Sequential accumulation stage downstream of the 9x9 signed Baugh-Wooley multiplier. It consumes one 18-bit signed product per valid/ready handshake and sums a group of products into a saturating signed accumulator. Each completed group is presented on an output handshake together with a sticky overflow flag. Together with the multiplier it forms the MAC lane of the approximate datapath; product precision and approximation are set upstream and are transparent here.

## Interface
- MAC_OUT_WIDTH, 18: product width (signed, two's complement).
- ACC_WIDTH, 24: accumulator/result width; must be ≥ MAC_OUT_WIDTH.
- LEN_WIDTH, 8: group-length field width.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- clr_i  input  1  synchronous abort: discards the partial group.
- prod_valid_i  input  1  product valid.
- prod_ready_o  output  1  product ready.
- prod_i  input  MAC_OUT_WIDTH  signed product from multiplier `res`.
- prod_last_i  input  1  marks final product of a group (qualified by handshake).
- acc_len_i  input  LEN_WIDTH  group length; sampled on first accepted product of a group; 0 means unbounded (only prod_last_i closes).
- out_valid_o  output  1  group result valid.
- out_ready_i  input  1  consumer ready.
- out_data_o  output  ACC_WIDTH  signed saturated group sum.
- out_ovf_o  output  1  at least one saturation event within the group.

## Operation
- FSM states: ACC (prod_ready_o=1, out_valid_o=0), HOLD (prod_ready_o=0, out_valid_o=1).
- Accept = prod_valid_i & prod_ready_o. On accept: sign-extend prod_i to ACC_WIDTH+1, add to acc, saturate to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; a clip sets ovf_acc sticky; cnt increments.
- First accept of a group (cnt==0) latches acc_len_i into len_q; that product also counts toward len.
- Group closes on accept when prod_last_i=1, or when len_q≠0 and cnt==len_q-1. On close: out_data_o ← saturated sum including current product, out_ovf_o ← ovf_acc | current clip; acc, cnt, ovf_acc ← 0; state → HOLD.
- HOLD: out_data_o/out_ovf_o stable until out_valid_o & out_ready_i; then → ACC. No same-cycle accept in that cycle (prod_ready_o still 0).
- clr_i (any state): acc, cnt, ovf_acc, out_valid_o ← 0, state → ACC; the held result is dropped and an accept in the same cycle is ignored.
- Priority: rst > clr_i > handshakes.
- prod_valid_i may deassert freely between products; acc holds.

## Timing
- Reset: state ACC, acc=0, cnt=0, len_q=0, ovf_acc=0, out_valid_o=0, out_data_o=0, out_ovf_o=0. prod_ready_o=0 while rst=1, 1 in the first cycle after release.
- Throughput: one product/cycle in ACC.
- Latency: closing product accepted at edge t → out_valid_o=1 from t+1. First accept of the next group is possible at the edge after the output handshake (≥1 bubble).
- cnt width LEN_WIDTH; with len_q=0 it wraps silently and grouping relies on prod_last_i.
- prod_last_i and len terminating on the same accept: a single close.
- rst mid-group or in HOLD: everything returns to reset values on that edge; no output emitted.

## Structure
- Package mac_pkg: ACC_WIDTH and LEN_WIDTH defaults, the state enum (ACC, HOLD), and a saturation-bounds function.
- Sub-module sat_add: combinational signed (ACC_WIDTH+1)-bit add with clamp and clip flag; instantiated once.
- All state lives in the top: FSM, acc, cnt, len_q, ovf_acc, output register.

## Test plan
- len=4, products 100, -50, 255, -1, out_ready_i=1 → out_data_o=304, out_ovf_o=0, out_valid_o the cycle after 4th accept, for one cycle.
- ACC_WIDTH=20, len=8, eight products of 65536 → out_data_o=524287, out_ovf_o=1; then len=2, products -3, 3 → out_data_o=0, out_ovf_o=0 (sticky cleared).
- len=0, products 7, 7, 7 with prod_last_i on the third → out_data_o=21; with len=5, prod_last_i on the 2nd product (10, 20) → out_data_o=30.
- out_ready_i held low 5 cycles after close → out_valid_o/out_data_o stable, prod_ready_o=0 throughout, prod_valid_i ignored; accept resumes the cycle after the handshake.
- len=4, two products 9, 9 then clr_i → no output; next group of len=1 with product -65536 → out_data_o=-65536.
- rst asserted in HOLD and in mid-group → all outputs at reset values next cycle, prod_ready_o=1 one cycle after release.
